serial_number_feeder: RTL and testbench

Upstream stage for the serial divisibility checkers. It accepts a W-bit number over a valid/ready handshake and clears the checker. It then shifts the number into the checker MSB-first, one bit per clock. After the last bit it samples the checker's divisibility flag and presents it, together with the original number, on a valid/ready output.

---
 rtl/serial_feeder_pkg.sv | 19 +
 rtl/serial_number_feeder_if.sv | 24 ++
 rtl/serial_number_feeder_piso.sv | 30 +++
 rtl/serial_number_feeder.sv | 133 +++++++++++++
 tb/tb_serial_number_feeder.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_feeder_pkg.sv
// Shared types and constants for the serial number feeder.
package serial_feeder_pkg;

    localparam int FEEDER_W_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        SHIFT  = 3'd2,
        SAMPLE = 3'd3,
        HOLD   = 3'd4
    } feeder_state_t;

    // Bit counter width: enough to hold W-1, never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_number_feeder_if.sv
// Number-in / result-out handshake bundle of the serial number feeder.
interface serial_number_feeder_if #(
    parameter int W = serial_feeder_pkg::FEEDER_W_DEFAULT
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_div;

    // Producer of numbers and consumer of results.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_div
    );

    // The feeder itself.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_div
    );
endinterface

// File: rtl/serial_number_feeder_piso.sv
// W-bit parallel-in serial-out register; shifts left, zero fill, MSB out.
module piso_shift_register #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);

    logic [W-1:0] q_r;

    // Parallel load takes priority over shifting.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= {W{1'b0}};
        end else if (load) begin
            q_r <= din;
        end else if (shift) begin
            q_r <= q_r << 1'b1;
        end else begin
            q_r <= q_r;
        end
    end

    assign msb = q_r[W-1];

endmodule

// File: rtl/serial_number_feeder.sv
// Feeds a W-bit number MSB-first into a serial divisibility checker and
// returns the checker's verdict together with the number.
module serial_number_feeder
    import serial_feeder_pkg::*;
#(
    parameter int W = FEEDER_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    serial_number_feeder_if.slave  bus,
    output logic                   chk_rst,
    output logic                   new_bit,
    output logic                   bit_valid,
    input  logic                   div_flag
);

    localparam int             CW       = cnt_width(W);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(W - 1);
    localparam logic [CW-1:0]  CNT_ZERO = CW'(0);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    feeder_state_t  state_r;
    logic [CW-1:0]  cnt_r;
    logic           in_ready_r;
    logic           out_valid_r;
    logic           out_div_r;
    logic [W-1:0]   out_data_r;
    logic           new_bit_r;
    logic           bit_valid_r;
    logic           chk_rst_r;

    logic           accept_s;
    logic           shift_s;
    logic           msb_s;

    assign accept_s = (state_r == IDLE) && bus.in_valid && in_ready_r;

    // The serial bit is registered, so the shifter runs one cycle ahead:
    // it advances on the CLEAR edge (presenting bit W-1) and on every SHIFT
    // edge except the last, giving exactly W shifts per number.
    assign shift_s = (state_r == CLEAR) || ((state_r == SHIFT) && (cnt_r != CNT_ZERO));

    piso_shift_register #(.W(W)) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (accept_s),
        .shift (shift_s),
        .din   (bus.in_data),
        .msb   (msb_s)
    );

    // Sequencer: state, bit counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= CNT_ZERO;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_div_r   <= 1'b0;
            out_data_r  <= {W{1'b0}};
            new_bit_r   <= 1'b0;
            bit_valid_r <= 1'b0;
            chk_rst_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    new_bit_r   <= 1'b0;
                    bit_valid_r <= 1'b0;
                    if (accept_s) begin
                        out_data_r <= bus.in_data;
                        in_ready_r <= 1'b0;
                        chk_rst_r  <= 1'b1;
                        state_r    <= CLEAR;
                    end else begin
                        in_ready_r <= 1'b1;
                        chk_rst_r  <= 1'b0;
                    end
                end
                CLEAR: begin
                    chk_rst_r   <= 1'b0;
                    cnt_r       <= CNT_LOAD;
                    new_bit_r   <= msb_s;
                    bit_valid_r <= 1'b1;
                    state_r     <= SHIFT;
                end
                SHIFT: begin
                    if (cnt_r == CNT_ZERO) begin
                        // Last bit is on the wire this cycle.
                        new_bit_r   <= 1'b0;
                        bit_valid_r <= 1'b0;
                        state_r     <= SAMPLE;
                    end else begin
                        cnt_r     <= cnt_r - CNT_ONE;
                        new_bit_r <= msb_s;
                    end
                end
                SAMPLE: begin
                    // Checker has absorbed all W bits; its flag is final now.
                    out_div_r   <= div_flag;
                    out_valid_r <= 1'b1;
                    state_r     <= HOLD;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    new_bit_r   <= 1'b0;
                    bit_valid_r <= 1'b0;
                    chk_rst_r   <= 1'b0;
                end
            endcase
        end
    end

    // The checker must be cleared in the very cycle the feeder is reset.
    assign chk_rst       = rst | chk_rst_r;
    assign new_bit       = new_bit_r;
    assign bit_valid     = bit_valid_r;
    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_div   = out_div_r;

endmodule

// File: tb/tb_serial_number_feeder.sv
// Self-checking bench for serial_number_feeder with a div-by-3/5 checker beside it.
module tb_serial_number_feeder;

    localparam int W = 16;

    logic clk;
    logic rst;
    logic chk_rst;
    logic new_bit;
    logic bit_valid;
    logic div_flag;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int chk_mod = 5;
    int cs;

    serial_number_feeder_if #(.W(W)) bus ();

    serial_number_feeder #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .chk_rst   (chk_rst),
        .new_bit   (new_bit),
        .bit_valid (bit_valid),
        .div_flag  (div_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Serial mod-N checker: remainder of the bits seen so far.
    always @(posedge clk) begin
        if (chk_rst) cs <= 0;
        else         cs <= (cs * 2 + (new_bit ? 1 : 0)) % chk_mod;
    end
    assign div_flag = (cs == 0);

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offer d and return at the negedge of the CLEAR cycle (t+1).
    task automatic send(input logic [15:0] d, output bit ok);
        int n;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 100);
        if (!ok) begin
            check("accept_timeout", 32'd0, 32'd1);
            bus.in_valid = 1'b0;
        end else begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
    endtask

    // Full transaction with cycle-exact latency checks.
    task automatic run_one(input logic [15:0] d, input int m, input logic exp_div, input int hold_delay);
        logic [15:0] bits;
        bit ok;
        bit bv_ok;
        bit stable;
        chk_mod = m;
        send(d, ok);
        if (ok) begin
            check("clear_chk_rst", chk_rst, 1);
            check("clear_in_ready", bus.in_ready, 0);
            bits  = 16'd0;
            bv_ok = 1'b1;
            for (int i = 0; i < W; i++) begin
                @(negedge clk);
                bits = {bits[14:0], new_bit};
                if (bit_valid !== 1'b1) bv_ok = 1'b0;
            end
            check("bit_seq", bits, d);
            check("bit_valid_window", bv_ok, 1);
            @(negedge clk);
            check("sample_no_valid", bus.out_valid, 0);
            @(negedge clk);
            check("out_valid", bus.out_valid, 1);
            check("out_data", bus.out_data, d);
            check("out_div", bus.out_div, exp_div);
            stable = 1'b1;
            for (int k = 0; k < hold_delay; k++) begin
                @(negedge clk);
                if (bus.out_valid !== 1'b1 || bus.out_data !== d || bus.out_div !== exp_div) stable = 1'b0;
            end
            if (hold_delay > 0) check("hold_stable", stable, 1);
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
            check("consumed_valid", bus.out_valid, 0);
            check("consumed_ready", bus.in_ready, 1);
        end
    endtask

    typedef struct {
        logic [15:0] data;
        int          m;
        logic        exp_div;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [15:0] d;
        int m;
        bit ok;
        bit stable;
        bit seen;
        int n;
        int idx;
        int acc_cyc [$];
        logic [15:0] res_data [$];
        logic res_div [$];
        logic [15:0] b2b [3];

        vecs[0] = '{16'd25,    5, 1'b1};
        vecs[1] = '{16'd7,     5, 1'b0};
        vecs[2] = '{16'd7,     3, 1'b0};
        vecs[3] = '{16'd21,    3, 1'b1};
        vecs[4] = '{16'd0,     5, 1'b1};
        vecs[5] = '{16'hFFFF,  5, 1'b1};
        vecs[6] = '{16'h8000,  5, 1'b0};
        vecs[7] = '{16'd10,    5, 1'b1};

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'd0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_chk_rst", chk_rst, 1);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_div", bus.out_div, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_new_bit", new_bit, 0);
        check("rst_bit_valid", bit_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", bus.in_ready, 1);
        check("post_rst_chk_rst", chk_rst, 0);

        // Directed table
        for (int i = 0; i < 8; i++) run_one(vecs[i].data, vecs[i].m, vecs[i].exp_div, 0);

        // Long hold with ignored in_valid pulses
        chk_mod = 5;
        send(16'd40, ok);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("hold_reach", (n < 100), 1);
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.in_valid = k[0];
            bus.in_data  = 16'd123;
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.out_data !== 16'd40 || bus.out_div !== 1'b1 || bus.in_ready !== 1'b0)
                stable = 1'b0;
        end
        check("hold10_stable", stable, 1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("hold10_release_valid", bus.out_valid, 0);
        check("hold10_release_ready", bus.in_ready, 1);
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (chk_rst !== 1'b0 || bit_valid !== 1'b0 || bus.in_ready !== 1'b1) seen = 1'b1;
        end
        check("hold10_no_accept", seen, 0);

        // Reset in the 5th SHIFT cycle
        chk_mod = 5;
        send(16'h1234, ok);
        repeat (5) @(negedge clk);
        check("mid_shift_active", bit_valid, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_chk_rst", chk_rst, 1);
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_in_ready", bus.in_ready, 1);
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_bit_valid", bit_valid, 0);
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        check("mid_rst_discarded", seen, 0);
        run_one(16'd10, 5, 1'b1, 0);

        // Back-to-back with in_valid and out_ready held high
        b2b[0] = 16'd15;
        b2b[1] = 16'd16;
        b2b[2] = 16'd20;
        chk_mod = 5;
        @(negedge clk);
        idx = 0;
        bus.in_valid  = 1'b1;
        bus.in_data   = b2b[0];
        bus.out_ready = 1'b1;
        for (int c = 0; c < 3 * (W + 4) + 20; c++) begin
            if (bus.out_valid === 1'b1) begin
                res_data.push_back(bus.out_data);
                res_div.push_back(bus.out_div);
            end
            if (bus.in_valid && bus.in_ready === 1'b1) begin
                acc_cyc.push_back(cyc);
                idx++;
            end else if (bus.in_ready !== 1'b1) begin
                if (idx < 3) bus.in_data = b2b[idx];
                else         bus.in_valid = 1'b0;
            end
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("b2b_accepts", acc_cyc.size(), 3);
        check("b2b_results", res_data.size(), 3);
        if (acc_cyc.size() == 3) begin
            check("b2b_spacing0", acc_cyc[1] - acc_cyc[0], W + 4);
            check("b2b_spacing1", acc_cyc[2] - acc_cyc[1], W + 4);
        end
        for (int i = 0; i < res_data.size() && i < 3; i++) begin
            check("b2b_data", res_data[i], b2b[i]);
            check("b2b_div", res_div[i], ((b2b[i] % 5) == 0));
        end

        // Randomized numbers against arithmetic reference
        for (int r = 0; r < 24; r++) begin
            d = 16'($urandom_range(0, 65535));
            m = ($urandom_range(0, 1) == 1) ? 5 : 3;
            if ($urandom_range(0, 2) == 0) d = d - 16'(int'(d) % m);
            run_one(d, m, ((int'(d) % m) == 0), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
